// File: rtl/ft_alu_sequencer.sv
// Fault-tolerance sequencer: borrows the shared ALU in core-idle cycles to run REDL/FTCHK,
// and keeps a saturating fault counter with a sticky alarm.
module ft_alu_sequencer #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned COUNT_WIDTH     = 8,
  parameter int unsigned FAULT_THRESHOLD = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [1:0]             req_cmd,
  input  logic [1:0]             req_level,
  input  logic [DATA_WIDTH-1:0]  req_data,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [DATA_WIDTH-1:0]  resp_data,
  output logic                   resp_fault,
  output logic                   resp_err,
  input  logic                   alu_free,
  output logic                   alu_owned,
  output logic [5:0]             ALU_operation,
  output logic [DATA_WIDTH-1:0]  operand_A,
  output logic [DATA_WIDTH-1:0]  operand_B,
  input  logic [DATA_WIDTH-1:0]  ALU_result,
  input  logic                   clear_faults,
  output logic [COUNT_WIDTH-1:0] fault_count,
  output logic                   fault_alarm
);

  localparam logic [5:0]             OpRedl    = 6'd16;
  localparam logic [5:0]             OpFtchk   = 6'd18;
  localparam logic [1:0]             CmdCheck  = 2'd1;
  localparam logic [COUNT_WIDTH-1:0] CountMax  = '1;
  localparam logic [COUNT_WIDTH-1:0] Threshold = COUNT_WIDTH'(FAULT_THRESHOLD);

  typedef enum logic [1:0] {StIdle, StEnc, StChk, StResp} state_e;

  state_e                state_q;
  logic [1:0]            cmd_q;
  logic [1:0]            level_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [2:0]            level_code;
  logic                  alu_slot;
  logic                  fault_inc;

  assign level_code = {1'b0, level_q} + 3'd2;
  assign alu_slot   = alu_free && (state_q == StEnc || state_q == StChk);
  assign fault_inc  = alu_slot && (state_q == StChk) && (ALU_result != '0);
  assign req_ready  = (state_q == StIdle);

  // ALU drive must follow alu_free within the same cycle, so it is combinational.
  always_comb begin
    alu_owned     = alu_slot;
    ALU_operation = '0;
    operand_A     = '0;
    operand_B     = '0;
    if (alu_slot) begin
      ALU_operation = (state_q == StChk) ? OpFtchk : OpRedl;
      operand_A     = data_q;
      operand_B     = {{(DATA_WIDTH-3){1'b0}}, level_code};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      cmd_q      <= '0;
      level_q    <= '0;
      data_q     <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_fault <= 1'b0;
      resp_err   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            cmd_q      <= req_cmd;
            level_q    <= req_level;
            data_q     <= req_data;
            resp_fault <= 1'b0;
            resp_err   <= 1'b0;
            unique case (req_cmd)
              2'd0:       state_q <= StEnc;
              2'd1, 2'd2: state_q <= StChk;
              default: begin
                resp_err   <= 1'b1;
                resp_data  <= '0;
                resp_valid <= 1'b1;
                state_q    <= StResp;
              end
            endcase
          end
        end
        StChk: begin
          if (alu_free) begin
            resp_data  <= ALU_result;
            resp_fault <= (ALU_result != '0);
            if (cmd_q == CmdCheck) begin
              resp_valid <= 1'b1;
              state_q    <= StResp;
            end else begin
              state_q <= StEnc;
            end
          end
        end
        StEnc: begin
          if (alu_free) begin
            resp_data  <= ALU_result;
            resp_valid <= 1'b1;
            state_q    <= StResp;
          end
        end
        StResp: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Clear beats a same-cycle increment; alarm compares the registered count.
  always_ff @(posedge clock) begin
    if (reset || clear_faults) begin
      fault_count <= '0;
      fault_alarm <= 1'b0;
    end else begin
      if (fault_inc && fault_count != CountMax) fault_count <= fault_count + 1'b1;
      if (fault_count >= Threshold) fault_alarm <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ft_alu_sequencer.sv
// Directed bench for ft_alu_sequencer with a behavioural model of the REDL/FTCHK ALU ops.
module tb_ft_alu_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_cmd = '0;
  logic [1:0]  req_level = '0;
  logic [31:0] req_data = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_data;
  logic        resp_fault;
  logic        resp_err;
  logic        alu_free = 1'b1;
  logic        alu_owned;
  logic [5:0]  ALU_operation;
  logic [31:0] operand_A;
  logic [31:0] operand_B;
  logic [31:0] ALU_result;
  logic        clear_faults = 1'b0;
  logic [7:0]  fault_count;
  logic        fault_alarm;

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  ft_alu_sequencer #(
    .DATA_WIDTH(32),
    .COUNT_WIDTH(8),
    .FAULT_THRESHOLD(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_cmd(req_cmd),
    .req_level(req_level),
    .req_data(req_data),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_data(resp_data),
    .resp_fault(resp_fault),
    .resp_err(resp_err),
    .alu_free(alu_free),
    .alu_owned(alu_owned),
    .ALU_operation(ALU_operation),
    .operand_A(operand_A),
    .operand_B(operand_B),
    .ALU_result(ALU_result),
    .clear_faults(clear_faults),
    .fault_count(fault_count),
    .fault_alarm(fault_alarm)
  );

  // Model of the shared ALU: REDL replicates the low share, FTCHK reports share differences.
  function automatic logic [31:0] alu_model(input logic [5:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [15:0] d16;
    logic [7:0]  d1, d2, d3;
    alu_model = 32'hDEAD_BEEF;
    if (op == 6'd16) begin
      case (b)
        32'd2:   alu_model = {a[15:0], a[15:0]};
        32'd3:   alu_model = {~a[15:0], a[15:0]};
        32'd4:   alu_model = {a[7:0], a[7:0], a[7:0], a[7:0]};
        32'd5:   alu_model = {~a[7:0], a[7:0], ~a[7:0], a[7:0]};
        default: alu_model = 32'hDEAD_BEEF;
      endcase
    end else if (op == 6'd18) begin
      case (b)
        32'd2: begin d16 = a[31:16] ^ a[15:0];  alu_model = {d16, d16}; end
        32'd3: begin d16 = a[31:16] ^ ~a[15:0]; alu_model = {d16, d16}; end
        32'd4: begin
          d1 = a[15:8] ^ a[7:0]; d2 = a[23:16] ^ a[7:0]; d3 = a[31:24] ^ a[7:0];
          alu_model = {d3, d2, d1, d1 | d2 | d3};
        end
        32'd5: begin
          d1 = a[15:8] ^ ~a[7:0]; d2 = a[23:16] ^ a[7:0]; d3 = a[31:24] ^ ~a[7:0];
          alu_model = {d3, d2, d1, d1 | d2 | d3};
        end
        default: alu_model = 32'hDEAD_BEEF;
      endcase
    end
  endfunction

  always_comb ALU_result = alu_model(ALU_operation, operand_A, operand_B);

  task automatic run_req(input logic [1:0] cmd, input logic [1:0] lvl, input logic [31:0] data,
                         input int stall, input bit clr, input int hold,
                         input logic [31:0] exp_data, input bit exp_fault, input bit exp_err,
                         input int exp_lat, input logic [7:0] exp_cnt, input bit exp_alarm,
                         input string name);
    int lat;
    bit got;
    logic [5:0]  exp_op;
    logic [31:0] exp_b;
    exp_op = (cmd == 2'd0) ? 6'd16 : 6'd18;
    exp_b  = {30'd0, lvl} + 32'd2;
    @(negedge clock);
    n_vec++;
    if (req_ready !== 1'b1) begin
      n_err++; $display("FAIL %s req_ready idle: got %b want 1", name, req_ready);
    end
    req_valid = 1'b1; req_cmd = cmd; req_level = lvl; req_data = data;
    alu_free = (stall == 0);
    @(posedge clock);
    #1 req_valid = 1'b0; req_data = '0;
    lat = 0; got = 0;
    while (!got && lat < 30) begin
      @(negedge clock);
      lat++;
      if (resp_valid === 1'b1) begin
        got = 1;
      end else begin
        if (lat <= stall) begin
          n_vec++;
          if (alu_owned !== 1'b0 || ALU_operation !== 6'd0 || operand_A !== 32'd0 ||
              operand_B !== 32'd0) begin
            n_err++;
            $display("FAIL %s stall%0d alu: owned %b op %0d a %h b %h want all 0",
                     name, lat, alu_owned, ALU_operation, operand_A, operand_B);
          end
        end
        alu_free = (lat > stall);
        clear_faults = (lat == stall + 1) ? clr : 1'b0;
        if (stall > 0 && lat == stall + 1) begin
          #1;
          n_vec++;
          if (alu_owned !== 1'b1 || ALU_operation !== exp_op || operand_A !== data ||
              operand_B !== exp_b) begin
            n_err++;
            $display("FAIL %s owned alu: owned %b op %0d a %h b %h want 1 %0d %h %h",
                     name, alu_owned, ALU_operation, operand_A, operand_B, exp_op, data, exp_b);
          end
        end
      end
    end
    clear_faults = 1'b0;
    alu_free = 1'b1;
    n_vec++;
    if (!got || lat != exp_lat) begin
      n_err++; $display("FAIL %s latency: got %0d (valid %b) want %0d", name, lat, got, exp_lat);
    end
    n_vec++;
    if (resp_data !== exp_data) begin
      n_err++; $display("FAIL %s resp_data: got %h want %h", name, resp_data, exp_data);
    end
    n_vec++;
    if (resp_fault !== exp_fault || resp_err !== exp_err) begin
      n_err++;
      $display("FAIL %s fault/err: got %b/%b want %b/%b", name, resp_fault, resp_err,
               exp_fault, exp_err);
    end
    n_vec++;
    if (fault_count !== exp_cnt || fault_alarm !== exp_alarm) begin
      n_err++;
      $display("FAIL %s count/alarm: got %0d/%b want %0d/%b", name, fault_count, fault_alarm,
               exp_cnt, exp_alarm);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      n_vec++;
      if (resp_valid !== 1'b1 || resp_data !== exp_data || resp_fault !== exp_fault ||
          req_ready !== 1'b0) begin
        n_err++;
        $display("FAIL %s hold%0d: valid %b data %h fault %b ready %b want 1 %h %b 0",
                 name, i, resp_valid, resp_data, resp_fault, req_ready, exp_data, exp_fault);
      end
    end
    resp_ready = 1'b1;
    @(negedge clock);
    resp_ready = 1'b0;
    n_vec++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s release: valid %b ready %b want 0 1", name, resp_valid, req_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    n_vec++;
    if (resp_valid !== 1'b0 || resp_data !== 32'd0 || resp_fault !== 1'b0 ||
        resp_err !== 1'b0 || fault_count !== 8'd0 || fault_alarm !== 1'b0 ||
        alu_owned !== 1'b0 || ALU_operation !== 6'd0 || operand_A !== 32'd0 ||
        operand_B !== 32'd0 || req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset state: valid %b data %h cnt %0d alarm %b owned %b ready %b",
               resp_valid, resp_data, fault_count, fault_alarm, alu_owned, req_ready);
    end
    reset = 1'b0;
  endtask

  task automatic test_encode();
    run_req(2'd0, 2'd0, 32'h0000ABCD, 0, 0, 0, 32'hABCDABCD, 0, 0, 2, 8'd0, 0, "enc_l0");
    run_req(2'd0, 2'd1, 32'h0000ABCD, 0, 0, 0, 32'h5432ABCD, 0, 0, 2, 8'd0, 0, "enc_l1");
    run_req(2'd0, 2'd2, 32'h000000A5, 0, 0, 0, 32'hA5A5A5A5, 0, 0, 2, 8'd0, 0, "enc_l2");
    run_req(2'd0, 2'd3, 32'h000000A5, 0, 0, 0, 32'h5AA55AA5, 0, 0, 2, 8'd0, 0, "enc_l3");
  endtask

  task automatic test_check_clean();
    run_req(2'd1, 2'd0, 32'hABCDABCD, 0, 0, 0, 32'h0, 0, 0, 2, 8'd0, 0, "chk_ok_l0");
    run_req(2'd1, 2'd1, 32'h5432ABCD, 0, 0, 0, 32'h0, 0, 0, 2, 8'd0, 0, "chk_ok_l1");
  endtask

  task automatic test_arbitration();
    run_req(2'd1, 2'd0, 32'hABCDABCD, 3, 0, 0, 32'h0, 0, 0, 5, 8'd0, 0, "chk_stall3");
  endtask

  task automatic test_reset_mid_enc();
    @(negedge clock);
    req_valid = 1'b1; req_cmd = 2'd0; req_level = 2'd0; req_data = 32'h0000ABCD;
    alu_free = 1'b0;
    @(posedge clock);
    #1 req_valid = 1'b0;
    @(negedge clock);
    n_vec++;
    if (alu_owned !== 1'b0 || req_ready !== 1'b0) begin
      n_err++; $display("FAIL rst_mid in_enc: owned %b ready %b want 0 0", alu_owned, req_ready);
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    alu_free = 1'b1;
    n_vec++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || alu_owned !== 1'b0 ||
        resp_data !== 32'd0) begin
      n_err++;
      $display("FAIL rst_mid after: ready %b valid %b owned %b data %h want 1 0 0 0",
               req_ready, resp_valid, alu_owned, resp_data);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      n_vec++;
      if (resp_valid !== 1'b0 || alu_owned !== 1'b0) begin
        n_err++;
        $display("FAIL rst_mid idle%0d: valid %b owned %b want 0 0", i, resp_valid, alu_owned);
      end
    end
  endtask

  task automatic test_faults();
    run_req(2'd1, 2'd0, 32'hABCDABCC, 0, 0, 0, 32'h00010001, 1, 0, 2, 8'd1, 0, "chk_fault");
    run_req(2'd2, 2'd3, 32'h5AA55AA4, 0, 0, 5, 32'h5BA45BA4, 1, 0, 3, 8'd2, 1, "scrub_l3");
    run_req(2'd1, 2'd0, 32'hABCDABCC, 1, 1, 0, 32'h00010001, 1, 0, 3, 8'd0, 0, "clr_vs_inc");
  endtask

  task automatic test_reserved();
    run_req(2'd3, 2'd0, 32'h12345678, 0, 0, 0, 32'h0, 0, 1, 1, 8'd0, 0, "reserved");
    run_req(2'd0, 2'd0, 32'h00001234, 0, 0, 0, 32'h12341234, 0, 0, 2, 8'd0, 0, "err_clears");
  endtask

  initial begin
    test_reset();
    test_encode();
    test_check_clean();
    test_arbitration();
    test_reset_mid_enc();
    test_faults();
    test_reserved();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/ft_alu_sequencer.md
Name: ft_alu_sequencer

Overview:
- Sequences the shared combinational ALU through the fault-tolerance opcodes for software-requested redundancy operations.
- Redundancy encode uses op 16, REDL. Integrity check uses op 18, FTCHK.
- Arbitrates the ALU against the core pipeline: the core always wins, and the sequencer borrows the ALU only in cycles the core leaves free.
- Maintains a saturating fault counter and a sticky alarm that feeds the countermeasure and response logic.

Parameters:
DATA_WIDTH, 32, ALU operand width; only 32 is supported.
COUNT_WIDTH, 8, width of the saturating fault counter.
FAULT_THRESHOLD, 4, fault_count value at or above which fault_alarm sets.

Ports:
clock  in  1  system clock.
reset  in  1  synchronous, active-high reset.
req_valid  in  1  request valid.
req_ready  out  1  sequencer can accept a request.
req_cmd  in  2  0=ENCODE, 1=CHECK, 2=SCRUB, 3=reserved.
req_level  in  2  0=2-way, 1=2-way complemented, 2=4-way, 3=4-way complemented.
req_data  in  DATA_WIDTH  raw value (ENCODE) or redundant word (CHECK/SCRUB).
resp_valid  out  1  response valid.
resp_ready  in  1  consumer accepts the response.
resp_data  out  DATA_WIDTH  encoded word (ENCODE/SCRUB) or FTCHK syndrome (CHECK).
resp_fault  out  1  check found a nonzero syndrome.
resp_err  out  1  reserved command.
alu_free  in  1  core does not use the ALU this cycle.
alu_owned  out  1  sequencer drives the ALU this cycle; steers the external operand mux.
ALU_operation  out  6  opcode to the ALU.
operand_A  out  DATA_WIDTH  ALU operand A.
operand_B  out  DATA_WIDTH  ALU operand B.
ALU_result  in  DATA_WIDTH  combinational ALU result.
clear_faults  in  1  clears fault_count and fault_alarm.
fault_count  out  COUNT_WIDTH  saturating count of faulting checks.
fault_alarm  out  1  sticky alarm.

Behaviour:
- Reset: one clock cycle with reset high is sufficient.
  - Forces state IDLE; any in-flight transaction is dropped with no response.
  - All registered outputs clear to 0: resp_valid, resp_data, resp_fault, resp_err, fault_count, fault_alarm.
  - alu_owned=0 and ALU_operation/operand_A/operand_B=0 from the first cycle after reset.
- Level code: L = 2, 3, 4, 5 for req_level 0..3. operand_B = {29'b0, L} for both REDL and FTCHK.
- States:
  - IDLE
    - req_ready=1.
    - On req_valid, latch cmd, level and data, and clear resp_fault and resp_err.
    - Next state: cmd 0 -> ENC, cmd 1/2 -> CHK, cmd 3 -> RESP with resp_err=1 and resp_data=0.
  - CHK
    - While alu_free=0: hold; alu_owned=0; ALU outputs 0.
    - When alu_free=1: alu_owned=1, ALU_operation=18, operand_A=latched data.
    - Same clock edge: capture resp_data=ALU_result and resp_fault=(ALU_result!=0).
    - Next state: CHECK -> RESP, SCRUB -> ENC.
  - ENC
    - Same alu_free wait rule as CHK.
    - When alu_free=1: alu_owned=1, ALU_operation=16, operand_A=latched data.
    - SCRUB re-encodes from the low share; REDL ignores the upper bits.
    - Capture resp_data=ALU_result; next state RESP.
    - resp_fault keeps its value from CHK.
  - RESP
    - resp_valid=1; resp_data, resp_fault and resp_err are held stable.
    - On resp_ready: go to IDLE, resp_valid=0.
  - req_ready=0 in all states except IDLE.
- ALU outputs: outside an owned cycle, ALU_operation, operand_A and operand_B are 0.
- Latency from the accept edge T, with alu_free held high:
  - ENCODE: resp_valid at T+2.
  - CHECK: resp_valid at T+2.
  - SCRUB: resp_valid at T+3.
  - Reserved command: resp_valid at T+1.
  - Each cycle with alu_free=0 in CHK or ENC adds one cycle.
- Fault counter:
  - Increments by 1 on each CHK capture with resp_fault=1.
  - Saturates at 2^COUNT_WIDTH-1.
  - fault_alarm sets the cycle after fault_count reaches FAULT_THRESHOLD. It is sticky.
  - clear_faults zeroes both fault_count and fault_alarm. If clear_faults and an increment occur in the same cycle, clear wins and the increment is lost.
  - The counter does not affect request flow.

Test Plan:
- ENCODE level 0, data 0x0000ABCD, alu_free=1 -> resp_data=0xABCDABCD at T+2. Level 1 -> 0x5432ABCD. Level 2 with data 0x000000A5 -> 0xA5A5A5A5. Level 3 -> 0x5AA55AA5.
- CHECK level 0, data 0xABCDABCD -> resp_data=0, resp_fault=0, fault_count stays 0. Level 1 with 0x5432ABCD -> syndrome 0, no fault.
- CHECK level 0, data 0xABCDABCC -> resp_data=0x00010001, resp_fault=1, fault_count=1.
- SCRUB level 3, data 0x5AA55AA4 -> resp_data=0x5BA45BA4, resp_fault=1 (syndrome 0x01010101), resp_valid at T+3. Hold resp_ready=0 for 5 cycles -> outputs stable and req_ready=0 throughout.
- Arbitration: alu_free=0 for 3 cycles during CHK -> alu_owned=0 and ALU outputs 0 in those cycles; response arrives 3 cycles late. Assert reset mid-ENC -> IDLE next cycle, no resp_valid.
- FAULT_THRESHOLD=2:
  - Two faulting checks -> fault_alarm=1.
  - A third fault concurrent with clear_faults -> fault_count=0, fault_alarm=0.
  - Cmd 3 -> resp_err=1, resp_data=0 at T+1.
